data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts word requests (address, write data, byte enables, write flag) from the datapath, applies a fixed, configurable access latency, and returns read data with a one-cycle ready pulse. It also flags misaligned or out-of-range accesses. It sits between the datapath's dAddress/dWriteData/dReadData signals and the on-chip data RAM, and lets control logic be exercised under multi-cycle memory timing.

Parameters:
BASE_ADDR  32'h10010000  byte address of word 0 of the data RAM
DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 2
LATENCY  2  cycles from request sample to ready pulse; integer >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  1  request valid; requester holds it high until ready
we  input  1  1 = write, 0 = read; sampled with req
dAddress  input  32  byte address; must be word aligned
dWriteData  input  32  write data; sampled with req
be  input  4  byte enables for writes; be[i] covers bits [8i+7:8i]; ignored on reads
dReadData  output  32  read data; valid while ready=1, held until next response
ready  output  1  one-cycle response pulse
err  output  1  high together with ready when the access faulted

Behaviour:
- Reset (rst=1 at a clock edge): state goes to IDLE, ready=0, err=0, dReadData=0, latency counter cleared. Any in-flight access is aborted and no write is committed. RAM contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE: when req=1, capture we, dAddress, dWriteData and be, then compute the fault flag.
  - Fault if dAddress[1:0]!=0.
  - Fault if dAddress<BASE_ADDR.
  - Fault if (dAddress-BASE_ADDR)>>2 >= DEPTH_WORDS. Use 32-bit unsigned arithmetic with no wrap-around acceptance.
  - If LATENCY=1, go to RESP. Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Go to RESP on the cycle the counter reaches 1.
- RESP: ready=1 for exactly this cycle. Result: ready rises exactly LATENCY cycles after the edge at which req was sampled in IDLE.
  - No fault, write: RAM bytes with be[i]=1 are updated at the edge that ends the RESP cycle. be=4'b0000 changes nothing but is still acknowledged. dReadData is not updated.
  - No fault, read: dReadData = RAM[word index], full word, be ignored.
  - Fault: err=1 with ready, no RAM update, dReadData=0.
  - Next state is IDLE. req is ignored in RESP.
- Outside RESP: ready=0 and err=0. dReadData holds its last value.
- Sampling and throughput: req is sampled only in IDLE. A req still high in the cycle after ready is a new request. Peak throughput is one access per LATENCY+1 cycles.
- Ordering and hazards: a read following a write to the same word returns the written data, since the write commits before the next IDLE sample.
- Input stability: captured fields are frozen. Changes to dAddress, dWriteData, be or we during WAIT/RESP have no effect.
- Reset priority: rst asserted in any state, including RESP, takes priority. ready=0 on the following cycle, and a pending write in that RESP is not committed.

Test Plan:
- LATENCY=2, reset, write 32'hDEADBEEF to 0x10010004 with be=4'hF, then read the same address. Required: ready pulses 2 cycles after each req sample with err=0, and the read returns 32'hDEADBEEF.
- Partial write: prior word 32'h11223344, write 32'hAABBCCDD with be=4'b0101, then read. Required: 32'h11BB33DD.
- Misaligned: read at 0x10010002. Required: ready and err both high for 1 cycle, dReadData=0. A following read of 0x10010000 shows that word unchanged.
- Range edges: access BASE_ADDR+4*DEPTH_WORDS-4 gives err=0; access BASE_ADDR+4*DEPTH_WORDS gives err=1; access BASE_ADDR-4 gives err=1; access 32'hFFFFFFFC gives err=1 with no wrap.
- Reset mid-write: issue a write of 32'h0 to a word holding 32'hCAFEF00D, assert rst during WAIT. Required: ready stays 0. A subsequent read returns 32'hCAFEF00D.
- Back-to-back: hold req high across 3 reads with LATENCY=3. Required: ready pulses at exactly 4-cycle spacing with correct data each time. Also repeat with LATENCY=1 and require 2-cycle spacing.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: data-memory request/response bus between datapath and responder
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [3:0]  be;
  logic [31:0] dReadData;
  logic        ready;
  logic        err;
  modport master(output req, we, dAddress, dWriteData, be, input dReadData, ready, err);
  modport slave(input req, we, dAddress, dWriteData, be, output dReadData, ready, err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data RAM responder with alignment and range fault detection
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            we_q, fault_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q, rdata_q, resp_data;
  logic [3:0]      be_q;
  logic [29:0]     word_off;
  logic            fault;
  logic [31:0]     mem [DEPTH_WORDS];
  // word offset from the RAM base; out-of-range includes addresses below base without wrap acceptance
  assign word_off = bus.dAddress[31:2] - BASE_ADDR[31:2];
  assign fault    = |bus.dAddress[1:0] || bus.dAddress < BASE_ADDR || word_off >= 30'(DEPTH_WORDS);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state and response outputs; read data is presented live during RESP and held afterwards
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.req) state_nx = LATENCY == 1 ? RESP : WAIT;
    else if (state == WAIT && cnt == CW'(1)) state_nx = RESP;
    else if (state == RESP) state_nx = IDLE;
    resp_data     = fault_q ? 32'h0 : we_q ? rdata_q : mem[idx_q];
    bus.ready     = state == RESP;
    bus.err       = state == RESP && fault_q;
    bus.dReadData = state == RESP ? resp_data : rdata_q;
  end
  // request capture, latency countdown and read-data hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req) begin
        we_q    <= bus.we;
        idx_q   <= word_off[AW-1:0];
        wdata_q <= bus.dWriteData;
        be_q    <= bus.be;
        fault_q <= fault;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == RESP) rdata_q <= resp_data;
    end
  end
  // byte-enabled write commits at the edge that ends RESP unless reset aborts it
  always_ff @(posedge clk)
    if (!rst && state == RESP && we_q && !fault_q)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of latency, byte writes, faults, reset abort and back-to-back timing
module tb_data_mem_responder;
  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  req = '0, we = '0, ready, err;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be [3];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] rd;
  logic        e;
  int          lat;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_if bus_i ();
    assign bus_i.req        = req[g];
    assign bus_i.we         = we[g];
    assign bus_i.dAddress   = addr[g];
    assign bus_i.dWriteData = wdata[g];
    assign bus_i.be         = be[g];
    assign rdata[g]         = bus_i.dReadData;
    assign ready[g]         = bus_i.ready;
    assign err[g]           = bus_i.err;
    data_mem_responder #(.LATENCY(g == 0 ? 2 : g == 1 ? 3 : 1)) dut (.clk(clk), .rst(rst), .bus(bus_i));
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] r, output logic ee, output int l);
    @(negedge clk);
    req[k] = 1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    @(posedge clk);
    l = 0; r = '0; ee = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready[k]) begin
        l = n; r = rdata[k]; ee = err[k];
        break;
      end
      we[k] = ~w; addr[k] = a ^ 32'h40; wdata[k] = ~d; be[k] = ~b;
    end
    req[k] = 0;
    if (l == 0) check("txn_timeout", 0, 1);
  endtask
  task automatic b2b(input int k, input logic [31:0] a, input logic [31:0] v0, input logic [31:0] v1,
                     input logic [31:0] v2, input int l);
    logic [31:0] exp [3];
    int cnt = 0, t_prev = 0;
    exp[0] = v0; exp[1] = v1; exp[2] = v2;
    @(negedge clk);
    req[k] = 1; we[k] = 0; addr[k] = a; be[k] = 4'h0;
    for (int n = 1; n <= 60 && cnt < 3; n++) begin
      @(negedge clk);
      if (ready[k]) begin
        check("b2b_data", rdata[k], exp[cnt]);
        check("b2b_err", 32'(err[k]), 0);
        check(cnt == 0 ? "b2b_first" : "b2b_spacing", n - t_prev, cnt == 0 ? l : l + 1);
        t_prev = n;
        cnt++;
        addr[k] = a + 32'(4 * cnt);
        if (cnt == 3) req[k] = 0;
      end
    end
    req[k] = 0;
    if (cnt < 3) check("b2b_timeout", cnt, 3);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_ready", 32'(ready[0]), 0);
    check("rst_err", 32'(err[0]), 0);
    check("rst_rdata", rdata[0], 0);
    txn(0, 1, 32'h10010004, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("wr_lat", lat, 2);
    check("wr_err", 32'(e), 0);
    txn(0, 0, 32'h10010004, 32'h0, 4'h0, rd, e, lat);
    check("rd_lat", lat, 2);
    check("rd_err", 32'(e), 0);
    check("rd_data", rd, 32'hDEADBEEF);
    txn(0, 1, 32'h10010008, 32'h11223344, 4'hF, rd, e, lat);
    check("wr_holds_rdata", rd, 32'hDEADBEEF);
    txn(0, 1, 32'h10010008, 32'hAABBCCDD, 4'b0101, rd, e, lat);
    txn(0, 0, 32'h10010008, 32'h0, 4'h0, rd, e, lat);
    check("partial_wr", rd, 32'h11BB33DD);
    txn(0, 1, 32'h10010008, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    check("be0_ack", 32'(e), 0);
    check("be0_lat", lat, 2);
    txn(0, 0, 32'h10010008, 32'h0, 4'h0, rd, e, lat);
    check("be0_nochange", rd, 32'h11BB33DD);
    txn(0, 1, 32'h10010000, 32'h5555AAAA, 4'hF, rd, e, lat);
    txn(0, 0, 32'h10010002, 32'h0, 4'h0, rd, e, lat);
    check("mis_rd_err", 32'(e), 1);
    check("mis_rd_data", rd, 0);
    check("mis_rd_lat", lat, 2);
    txn(0, 1, 32'h10010002, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    check("mis_wr_err", 32'(e), 1);
    txn(0, 0, 32'h10010000, 32'h0, 4'h0, rd, e, lat);
    check("mis_noupd_err", 32'(e), 0);
    check("mis_noupd", rd, 32'h5555AAAA);
    txn(0, 1, 32'h10010FFC, 32'h12345678, 4'hF, rd, e, lat);
    check("last_wr_err", 32'(e), 0);
    txn(0, 0, 32'h10010FFC, 32'h0, 4'h0, rd, e, lat);
    check("last_rd_err", 32'(e), 0);
    check("last_rd", rd, 32'h12345678);
    txn(0, 0, 32'h10011000, 32'h0, 4'h0, rd, e, lat);
    check("past_end_err", 32'(e), 1);
    check("past_end_data", rd, 0);
    txn(0, 0, 32'h1000FFFC, 32'h0, 4'h0, rd, e, lat);
    check("below_base_err", 32'(e), 1);
    txn(0, 0, 32'hFFFFFFFC, 32'h0, 4'h0, rd, e, lat);
    check("top_nowrap_err", 32'(e), 1);
    txn(0, 1, 32'h1001000C, 32'hCAFEF00D, 4'hF, rd, e, lat);
    @(negedge clk);
    req[0] = 1; we[0] = 1; addr[0] = 32'h1001000C; wdata[0] = 32'h0; be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("wait_ready", 32'(ready[0]), 0);
    rst = 1; req[0] = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_wait_ready", 32'(ready[0]), 0);
    check("rst_wait_rdata", rdata[0], 0);
    @(negedge clk);
    check("rst_wait_ready2", 32'(ready[0]), 0);
    txn(0, 0, 32'h1001000C, 32'h0, 4'h0, rd, e, lat);
    check("rst_wait_keep", rd, 32'hCAFEF00D);
    @(negedge clk);
    req[0] = 1; we[0] = 1; addr[0] = 32'h1001000C; wdata[0] = 32'h0; be[0] = 4'hF;
    for (int n = 0; n < 10 && !ready[0]; n++) @(negedge clk);
    check("resp_seen", 32'(ready[0]), 1);
    rst = 1; req[0] = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_resp_ready", 32'(ready[0]), 0);
    txn(0, 0, 32'h1001000C, 32'h0, 4'h0, rd, e, lat);
    check("rst_resp_keep", rd, 32'hCAFEF00D);
    for (int k = 1; k < 3; k++) begin
      txn(k, 1, 32'h10010010, 32'hA1A1A1A1, 4'hF, rd, e, lat);
      check(k == 1 ? "lat3_wr" : "lat1_wr", lat, k == 1 ? 3 : 1);
      txn(k, 1, 32'h10010014, 32'hB2B2B2B2, 4'hF, rd, e, lat);
      txn(k, 1, 32'h10010018, 32'hC3C3C3C3, 4'hF, rd, e, lat);
      b2b(k, 32'h10010010, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, k == 1 ? 3 : 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
